// File: rtl/gray_pkg.sv
// Shared constants, count-direction type and Gray helper for the Gray code counter.
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_WIDTH_MAX     = 16;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } count_dir_t;

    // Operates at the maximum width; narrower callers zero-extend and truncate.
    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_code_counter_if.sv
// Handshake bundle between the Gray code counter and its producer/consumer.
// The dir signal exists only when GRAY_CNT_UPDOWN_EN is defined.
interface gray_code_counter_if #(
    parameter int WIDTH = gray_pkg::GRAY_WIDTH_DEFAULT
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
`ifdef GRAY_CNT_UPDOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] gray_out;
    logic             out_valid;
    logic             out_ready;
    logic             wrap;

    modport master (
`ifdef GRAY_CNT_UPDOWN_EN
        output dir,
`endif
        output en, load, load_val, out_ready,
        input  gray_out, out_valid, wrap
    );

    modport slave (
`ifdef GRAY_CNT_UPDOWN_EN
        input  dir,
`endif
        input  en, load, load_val, out_ready,
        output gray_out, out_valid, wrap
    );
endinterface

// File: rtl/gray_code_counter_binary_to_gray.sv
// Combinational binary-to-Gray converter: each Gray bit is the XOR of adjacent binary bits.
module binary_to_gray #(
    parameter int WIDTH = gray_pkg::GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

    assign gray[WIDTH-1] = bin[WIDTH-1];
endmodule

// File: rtl/gray_code_counter.sv
// Binary counter with registered Gray output and a valid/ready output slot.
// Define GRAY_CNT_UPDOWN_EN to add the dir input (1 = count down).
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    gray_code_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] gray_q,  gray_d;
    logic             valid_q, valid_d;
    logic             wrap_q,  wrap_d;

    logic       slot_free;
    logic       step;
    count_dir_t cnt_dir;

`ifdef GRAY_CNT_UPDOWN_EN
    assign cnt_dir = bus.dir ? DOWN : UP;
`else
    assign cnt_dir = UP;
`endif

    assign slot_free = !valid_q || bus.out_ready;
    assign step      = bus.en && !bus.load && slot_free;

    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            // Load overwrites whatever the consumer has not yet taken.
            cnt_d   = bus.load_val;
            valid_d = 1'b1;
        end else if (step) begin
            valid_d = 1'b1;
            if (cnt_dir == DOWN) begin
                cnt_d  = cnt_q - CNT_ONE;
                wrap_d = (cnt_q == '0);
            end else begin
                cnt_d  = cnt_q + CNT_ONE;
                wrap_d = (cnt_q == CNT_MAX);
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    binary_to_gray #(
        .WIDTH (WIDTH)
    ) u_binary_to_gray (
        .bin  (cnt_d),
        .gray (gray_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.gray_out  = gray_q;
    assign bus.out_valid = valid_q;
    assign bus.wrap      = wrap_q;
endmodule
